// File: rtl/ascon_encrypt_ctrl.sv
// rtl/ascon_encrypt_ctrl.sv - ASCON-128 two-block encryption sequencer driving an external round core
// Optional associated-data phase: define ASCON_AD_EN.

module ascon_encrypt_ctrl #(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [63:0]  iv,
  input  logic [63:0]  k0,
  input  logic [63:0]  k1,
  input  logic [63:0]  n0,
  input  logic [63:0]  n1,
  input  logic [63:0]  pln0,
  input  logic [63:0]  pln1,
`ifdef ASCON_AD_EN
  input  logic [63:0]  ad0,
`endif
  output logic [319:0] rnd_state_o,
  output logic [7:0]   rnd_const_o,
  input  logic [319:0] rnd_state_i,
  output logic         busy,
  output logic         done,
  output logic [63:0]  cyp0,
  output logic [63:0]  cyp1,
  output logic [63:0]  tag0,
  output logic [63:0]  tag1
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_KEY, S_AD, S_PBA, S_ADPAD, S_PBA2,
    S_ENC0, S_PB0, S_ENC1, S_PB1, S_PAD, S_FIN, S_TAG, S_DONE
  } state_e;

  // p^a walks r = 0..ROUNDS_A-1; p^b runs only the tail of that schedule.
  localparam logic [3:0] R_LAST = 4'(ROUNDS_A - 1);
  localparam logic [3:0] R_B0   = 4'(ROUNDS_A - ROUNDS_B);
  localparam logic [63:0] PAD_BIT = 64'h8000_0000_0000_0000;

  state_e       state_q, state_d;
  state_e       round_next;
  logic         is_round;
  logic [319:0] s_q, s_d;
  logic [3:0]   r_q, r_d;
  logic [63:0]  k0_q, k0_d, k1_q, k1_d;
  logic [63:0]  p0_q, p0_d, p1_q, p1_d;
  logic [63:0]  cyp0_q, cyp0_d, cyp1_q, cyp1_d;
  logic [63:0]  tag0_q, tag0_d, tag1_q, tag1_d;
  logic         done_q, done_d;
`ifdef ASCON_AD_EN
  logic [63:0]  ad_q, ad_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      s_q     <= '0;
      r_q     <= '0;
      k0_q    <= '0;
      k1_q    <= '0;
      p0_q    <= '0;
      p1_q    <= '0;
      cyp0_q  <= '0;
      cyp1_q  <= '0;
      tag0_q  <= '0;
      tag1_q  <= '0;
      done_q  <= 1'b0;
`ifdef ASCON_AD_EN
      ad_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      r_q     <= r_d;
      k0_q    <= k0_d;
      k1_q    <= k1_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      cyp0_q  <= cyp0_d;
      cyp1_q  <= cyp1_d;
      tag0_q  <= tag0_d;
      tag1_q  <= tag1_d;
      done_q  <= done_d;
`ifdef ASCON_AD_EN
      ad_q    <= ad_d;
`endif
    end
  end

  // State words: x0 = s[319:256], x1 = s[255:192], x2 = s[191:128], x3 = s[127:64], x4 = s[63:0].
  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    r_d        = r_q;
    k0_d       = k0_q;
    k1_d       = k1_q;
    p0_d       = p0_q;
    p1_d       = p1_q;
    cyp0_d     = cyp0_q;
    cyp1_d     = cyp1_q;
    tag0_d     = tag0_q;
    tag1_d     = tag1_q;
    done_d     = 1'b0;
    is_round   = 1'b0;
    round_next = S_IDLE;
`ifdef ASCON_AD_EN
    ad_d       = ad_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          s_d     = {iv, k0, k1, n0, n1};
          k0_d    = k0;
          k1_d    = k1;
          p0_d    = pln0;
          p1_d    = pln1;
          r_d     = '0;
          state_d = S_INIT;
`ifdef ASCON_AD_EN
          ad_d    = ad0;
`endif
        end
      end
      S_INIT: begin
        is_round   = 1'b1;
        round_next = S_KEY;
      end
      S_KEY: begin
        s_d[127:0] = s_q[127:0] ^ {k0_q, k1_q};
        r_d        = R_B0;
`ifdef ASCON_AD_EN
        state_d    = S_AD;
`else
        state_d    = S_ENC0;
`endif
      end
`ifdef ASCON_AD_EN
      S_AD: begin
        s_d[319:256] = s_q[319:256] ^ ad_q;
        state_d      = S_PBA;
      end
      S_PBA: begin
        is_round   = 1'b1;
        round_next = S_ADPAD;
      end
      S_ADPAD: begin
        s_d[319:256] = s_q[319:256] ^ PAD_BIT;
        r_d          = R_B0;
        state_d      = S_PBA2;
      end
      S_PBA2: begin
        is_round   = 1'b1;
        round_next = S_ENC0;
      end
`endif
      S_ENC0: begin
        s_d[319:256] = s_q[319:256] ^ p0_q;
        cyp0_d       = s_q[319:256] ^ p0_q;
        s_d[63:0]    = s_q[63:0] ^ 64'h1;
        r_d          = R_B0;
        state_d      = S_PB0;
      end
      S_PB0: begin
        is_round   = 1'b1;
        round_next = S_ENC1;
      end
      S_ENC1: begin
        s_d[319:256] = s_q[319:256] ^ p1_q;
        cyp1_d       = s_q[319:256] ^ p1_q;
        r_d          = R_B0;
        state_d      = S_PB1;
      end
      S_PB1: begin
        is_round   = 1'b1;
        round_next = S_PAD;
      end
      S_PAD: begin
        s_d[319:128] = s_q[319:128] ^ {PAD_BIT, k0_q, k1_q};
        r_d          = '0;
        state_d      = S_FIN;
      end
      S_FIN: begin
        is_round   = 1'b1;
        round_next = S_TAG;
      end
      S_TAG: begin
        tag0_d  = s_q[127:64] ^ k0_q;
        tag1_d  = s_q[63:0] ^ k1_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (is_round) begin
      s_d = rnd_state_i;
      r_d = r_q + 4'd1;
      if (r_q == R_LAST) state_d = round_next;
    end
  end

  assign rnd_state_o = s_q;
  assign rnd_const_o = is_round ? {4'hF - r_q, r_q} : 8'h00;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign cyp0        = cyp0_q;
  assign cyp1        = cyp1_q;
  assign tag0        = tag0_q;
  assign tag1        = tag1_q;

endmodule

// File: tb/tb_ascon_encrypt_ctrl.sv
// tb/tb_ascon_encrypt_ctrl.sv - self-checking bench for ascon_encrypt_ctrl with a reference ASCON-128 model
// Honours ASCON_AD_EN when defined.

module tb_ascon_encrypt_ctrl;

`ifdef ASCON_AD_EN
  localparam int LAT = 56;
`else
  localparam int LAT = 42;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [63:0]  iv, k0, k1, n0, n1, pln0, pln1;
`ifdef ASCON_AD_EN
  logic [63:0]  ad0;
`endif
  logic [319:0] rnd_state_o, rnd_state_i;
  logic [7:0]   rnd_const_o;
  logic         busy, done;
  logic [63:0]  cyp0, cyp1, tag0, tag1;

  typedef struct {
    logic [255:0] exp;
    int           acc;
  } sb_t;

  sb_t        sb[$];
  logic [7:0] cl[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_bad = 0;
  logic       busy_prev = 1'b0;

  always #5 clk = ~clk;

  ascon_encrypt_ctrl #(.ROUNDS_A(12), .ROUNDS_B(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .iv(iv), .k0(k0), .k1(k1), .n0(n0), .n1(n1), .pln0(pln0), .pln1(pln1),
`ifdef ASCON_AD_EN
    .ad0(ad0),
`endif
    .rnd_state_o(rnd_state_o), .rnd_const_o(rnd_const_o), .rnd_state_i(rnd_state_i),
    .busy(busy), .done(done), .cyp0(cyp0), .cyp1(cyp1), .tag0(tag0), .tag1(tag1)
  );

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [7:0] c);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    x2 = x2 ^ {56'h0, c};
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  // The round core the controller drives.
  assign rnd_state_i = ascon_round(rnd_state_o, rnd_const_o);

  function automatic logic [319:0] perm(input logic [319:0] s, input int n);
    logic [319:0] t;
    t = s;
    for (int i = 12 - n; i < 12; i++) t = ascon_round(t, 8'hF0 - 8'(15 * i));
    return t;
  endfunction

  function automatic logic [255:0] model(input logic [63:0] a_iv, a_k0, a_k1, a_n0, a_n1, a_p0, a_p1);
    logic [319:0] s;
    logic [63:0]  c0, c1;
    s = perm({a_iv, a_k0, a_k1, a_n0, a_n1}, 12);
    s[127:0] = s[127:0] ^ {a_k0, a_k1};
`ifdef ASCON_AD_EN
    s[319:256] = s[319:256] ^ ad0;
    s = perm(s, 6);
    s[319:256] = s[319:256] ^ 64'h8000_0000_0000_0000;
    s = perm(s, 6);
`endif
    s[0] = ~s[0];
    s[319:256] = s[319:256] ^ a_p0;
    c0 = s[319:256];
    s = perm(s, 6);
    s[319:256] = s[319:256] ^ a_p1;
    c1 = s[319:256];
    s = perm(s, 6);
    s[319:128] = s[319:128] ^ {64'h8000_0000_0000_0000, a_k0, a_k1};
    s = perm(s, 12);
    return {c0, c1, s[127:64] ^ a_k0, s[63:0] ^ a_k1};
  endfunction

  // Advance one cycle, sample at the falling edge, and push the expectation when an operation starts.
  task automatic tick();
    sb_t e;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    cl.push_back(rnd_const_o);
    if (busy === 1'b1 && busy_prev !== 1'b1) begin
      e.exp = model(iv, k0, k1, n0, n1, pln0, pln1);
      e.acc = cyc;
      sb.push_back(e);
    end
    busy_prev = busy;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    ok = (done === 1'b1);
  endtask

  task automatic set_nominal();
    iv   = 64'h80400C0600000000;
    k0   = 64'h265F1C12888E151A;
    k1   = 64'hC74F26B30A8C44B2;
    n0   = 64'h369C801F3AE8D0EA;
    n1   = 64'h9BF367D58FD211FF;
    pln0 = 64'h1234567890ABCDEF;
    pln1 = 64'h1234567890ABCDEF;
`ifdef ASCON_AD_EN
    ad0  = 64'h0;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    set_nominal();
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy cycle=%0d got=%b want=0", i, busy); end
      n_checks++;
      if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done cycle=%0d got=%b want=0", i, done); end
      n_checks++;
      if (rnd_const_o !== 8'h00) begin n_bad++; $display("FAIL reset_const cycle=%0d got=%h want=00", i, rnd_const_o); end
    end
    n_checks++;
    if ({cyp0, cyp1, tag0, tag1} !== 256'h0) begin
      n_bad++; $display("FAIL reset_outputs got=%h want=0", {cyp0, cyp1, tag0, tag1});
    end
    n_checks++;
    if (rnd_state_o !== 320'h0) begin n_bad++; $display("FAIL reset_state got=%h want=0", rnd_state_o); end
  endtask

  task automatic test_nominal();
    sb_t        e;
    bit         ok;
    int         plan[$];
    logic [7:0] ec[$];
    set_nominal();
    start = 1'b1;
    cl.delete();
    tick();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL nominal_busy got=%b want=1", busy); end
    wait_done(100, ok);
    n_checks++;
    if (!ok) begin
      n_bad++; $display("FAIL nominal_timeout got=no_done want=done");
    end else begin
      n_checks++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL nominal_busy_at_done got=%b want=0", busy); end
      n_checks++;
      if (sb.size() != 1) begin
        n_bad++; $display("FAIL nominal_sb got=%0d want=1", sb.size());
      end else begin
        e = sb.pop_front();
        n_checks++;
        if (cyc - e.acc !== LAT) begin n_bad++; $display("FAIL nominal_latency got=%0d want=%0d", cyc - e.acc, LAT); end
        n_checks++;
        if (cyp0 !== e.exp[255:192]) begin n_bad++; $display("FAIL nominal_cyp0 got=%h want=%h", cyp0, e.exp[255:192]); end
        n_checks++;
        if (cyp1 !== e.exp[191:128]) begin n_bad++; $display("FAIL nominal_cyp1 got=%h want=%h", cyp1, e.exp[191:128]); end
        n_checks++;
        if (tag0 !== e.exp[127:64]) begin n_bad++; $display("FAIL nominal_tag0 got=%h want=%h", tag0, e.exp[127:64]); end
        n_checks++;
        if (tag1 !== e.exp[63:0]) begin n_bad++; $display("FAIL nominal_tag1 got=%h want=%h", tag1, e.exp[63:0]); end
      end
    end
    // Positive entries are rounds of a permutation, negative entries are idle-constant cycles.
`ifdef ASCON_AD_EN
    plan = '{12, -2, 6, -1, 6, -1, 6, -1, 6, -1, 12, -3};
`else
    plan = '{12, -2, 6, -1, 6, -1, 12, -3};
`endif
    foreach (plan[j]) begin
      if (plan[j] > 0) begin
        for (int i = 12 - plan[j]; i < 12; i++) ec.push_back(8'hF0 - 8'(15 * i));
      end else begin
        repeat (-plan[j]) ec.push_back(8'h00);
      end
    end
    n_checks++;
    if (cl.size() != ec.size()) begin n_bad++; $display("FAIL const_count got=%0d want=%0d", cl.size(), ec.size()); end
    for (int i = 0; i < ec.size() && i < cl.size(); i++) begin
      n_checks++;
      if (cl[i] !== ec[i]) begin n_bad++; $display("FAIL const_seq idx=%0d got=%h want=%h", i, cl[i], ec[i]); end
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL done_width got=%b want=0", done); end
  endtask

  task automatic test_start_busy();
    sb_t e;
    int  acc, ndone;
    set_nominal();
    start = 1'b1;
    tick();
    acc = cyc;
    ndone = 0;
    for (int n = 0; n < LAT + 30; n++) begin
      if (cyc == acc + 4 || cyc == acc + 29) begin
        iv = ~iv; k0 = ~k0; k1 = ~k1; n0 = ~n0; n1 = ~n1; pln0 = ~pln0; pln1 = 64'h0;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_bad++; $display("FAIL busy_sb got=empty want=entry");
          end else begin
            e = sb.pop_front();
            n_checks++;
            if (cyc - e.acc !== LAT) begin n_bad++; $display("FAIL busy_latency got=%0d want=%0d", cyc - e.acc, LAT); end
            n_checks++;
            if ({cyp0, cyp1, tag0, tag1} !== e.exp) begin
              n_bad++; $display("FAIL busy_result got=%h want=%h", {cyp0, cyp1, tag0, tag1}, e.exp);
            end
          end
        end
      end
    end
    start = 1'b0;
    n_checks++;
    if (ndone != 1) begin n_bad++; $display("FAIL busy_done_count got=%0d want=1", ndone); end
    n_checks++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL busy_extra_ops got=%0d want=0", sb.size()); end
    set_nominal();
  endtask

  task automatic test_reset_mid();
    sb_t e;
    bit  ok, seen;
    set_nominal();
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < sb[0].acc + 20) tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    n_checks++;
    if ({cyp0, cyp1, tag0, tag1} !== 256'h0) begin
      n_bad++; $display("FAIL midrst_outputs got=%h want=0", {cyp0, cyp1, tag0, tag1});
    end
    n_checks++;
    if (rnd_const_o !== 8'h00 || rnd_state_o !== 320'h0) begin
      n_bad++; $display("FAIL midrst_core got=%h/%h want=0", rnd_const_o, rnd_state_o);
    end
    sb.delete();
    busy_prev = 1'b0;
    seen = 1'b0;
    repeat (3) begin tick(); if (done !== 1'b0) seen = 1'b1; end
    rst_n = 1'b1;
    repeat (LAT) begin tick(); if (done !== 1'b0) seen = 1'b1; end
    n_checks++;
    if (seen) begin n_bad++; $display("FAIL midrst_done got=pulse want=none"); end
    pln0 = 64'h0;
    pln1 = 64'hFFFF_FFFF_FFFF_FFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(100, ok);
    n_checks++;
    if (!ok || sb.size() == 0) begin
      n_bad++; $display("FAIL midrst_restart got=no_done want=done");
    end else begin
      e = sb.pop_front();
      n_checks++;
      if (cyc - e.acc !== LAT) begin n_bad++; $display("FAIL midrst_latency got=%0d want=%0d", cyc - e.acc, LAT); end
      n_checks++;
      if ({cyp0, cyp1, tag0, tag1} !== e.exp) begin
        n_bad++; $display("FAIL midrst_result got=%h want=%h", {cyp0, cyp1, tag0, tag1}, e.exp);
      end
    end
    tick();
    set_nominal();
  endtask

  task automatic test_back_to_back();
    sb_t e;
    int  prev, ndone;
    set_nominal();
    start = 1'b1;
    prev = -1;
    ndone = 0;
    for (int n = 0; n < 3 * (LAT + 1) + 20 && ndone < 3; n++) begin
      tick();
      if (done === 1'b1) begin
        ndone++;
        n_checks++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL b2b_sb op=%0d got=empty want=entry", ndone);
        end else begin
          e = sb.pop_front();
          n_checks++;
          if (cyc - e.acc !== LAT) begin n_bad++; $display("FAIL b2b_latency op=%0d got=%0d want=%0d", ndone, cyc - e.acc, LAT); end
          n_checks++;
          if ({cyp0, cyp1, tag0, tag1} !== e.exp) begin
            n_bad++; $display("FAIL b2b_result op=%0d got=%h want=%h", ndone, {cyp0, cyp1, tag0, tag1}, e.exp);
          end
        end
        if (prev >= 0) begin
          n_checks++;
          if (cyc - prev != LAT + 1) begin n_bad++; $display("FAIL b2b_interval got=%0d want=%0d", cyc - prev, LAT + 1); end
        end
        prev = cyc;
        pln0 = {$urandom, $urandom};
        pln1 = {$urandom, $urandom};
        if (ndone == 3) start = 1'b0;
      end
    end
    n_checks++;
    if (ndone != 3) begin n_bad++; $display("FAIL b2b_count got=%0d want=3", ndone); end
    repeat (3) tick();
    n_checks++;
    if (busy !== 1'b0 || sb.size() != 0) begin
      n_bad++; $display("FAIL b2b_idle got=busy%b/sb%0d want=0/0", busy, sb.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_nominal();
    test_start_busy();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
